// File: rtl/fft_band_color_mapper.sv
// fft_band_color_mapper
// Scans the FFT magnitude BRAM once per frame and sums the magnitudes into
// N_BANDS bands whose edges are set at run time. Each band total is shifted
// right by its own offset and clamped to a 4-bit level L. The level becomes a
// 12-bit {R,G,B} colour, and all colours are published together with a
// one-cycle done pulse.
//
// Optional feature macro: PEAK_HOLD_EN
//   When defined, each band keeps a held level that decays by one per frame.
//   The colour is derived from the held level instead of L.
//
// Ports:
//   clock, reset   system clock; asynchronous active-high reset
//   start          frame-ready pulse (ignored while busy or adjusting)
//   adjusting      offset edit in progress; blocks start
//   band_edges     edge[i] = exclusive upper address of band i (band 0 at LSBs)
//   offsets        4-bit right-shift amount per band
//   bram_addr      BRAM read address (holds its last value outside the scan)
//   bram_data      BRAM read data, valid RD_LAT cycles after the address
//   color          {R,G,B} per band, band 0 at LSBs
//   busy           frame in progress
//   done           one-cycle pulse when color updates
module fft_band_color_mapper #(
    parameter int unsigned N_BANDS = 7,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned ACC_W   = 26,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      adjusting,
    input  logic [N_BANDS*ADDR_W-1:0] band_edges,
    input  logic [N_BANDS*4-1:0]      offsets,
    output logic [ADDR_W-1:0]         bram_addr,
    input  logic [DATA_W-1:0]         bram_data,
    output logic [N_BANDS*12-1:0]     color,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, MAP} state_t;

    state_t state, state_nxt;

    logic [N_BANDS*ADDR_W-1:0] edges_q;
    logic [N_BANDS*4-1:0]      offs_q;
    logic [CNT_W-1:0]          drain_cnt;
    logic [ACC_W-1:0]          acc [N_BANDS];

    logic                      tag_v [RD_LAT];
    logic [BAND_W-1:0]         tag_b [RD_LAT];

    logic                      accept_c;
    logic [ADDR_W-1:0]         last_edge_in_c;
    logic [ADDR_W-1:0]         last_edge_c;
    logic [BAND_W-1:0]         scan_band_c;
    logic [ACC_W:0]            acc_sum_c;
    logic [ACC_W-1:0]          acc_sat_c;
    logic [3:0]                level_c [N_BANDS];
    logic [3:0]                shown_c [N_BANDS];
    logic [N_BANDS*12-1:0]     color_c;

    assign accept_c       = (state == IDLE) && start && !adjusting;
    assign last_edge_in_c = band_edges[(N_BANDS-1)*ADDR_W +: ADDR_W];
    assign last_edge_c    = edges_q[(N_BANDS-1)*ADDR_W +: ADDR_W];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept_c) state_nxt = (last_edge_in_c == '0) ? DRAIN : SCAN;
            SCAN:  if (bram_addr == last_edge_c - ADDR_W'(1)) state_nxt = DRAIN;
            DRAIN: if (drain_cnt == CNT_W'(RD_LAT - 1)) state_nxt = MAP;
            MAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Band of the current scan address: the smallest i with addr < edge[i].
    // Empty bands (edge <= previous edge) can never be selected.
    always_comb begin
        scan_band_c = '0;
        for (int i = N_BANDS - 1; i >= 0; i--) begin
            if (bram_addr < edges_q[i*ADDR_W +: ADDR_W]) scan_band_c = BAND_W'(i);
        end
    end

    // Tag pipeline delays valid/band by RD_LAT so they line up with bram_data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < RD_LAT; j++) begin
                tag_v[j] <= 1'b0;
                tag_b[j] <= '0;
            end
        end else begin
            tag_v[0] <= (state == SCAN);
            tag_b[0] <= scan_band_c;
            for (int j = 1; j < RD_LAT; j++) begin
                tag_v[j] <= tag_v[j-1];
                tag_b[j] <= tag_b[j-1];
            end
        end
    end

    // Saturating accumulate of the read that is currently returning
    assign acc_sum_c = {1'b0, acc[tag_b[RD_LAT-1]]} + (ACC_W+1)'(bram_data);
    assign acc_sat_c = acc_sum_c[ACC_W] ? '1 : acc_sum_c[ACC_W-1:0];

    // Level per band: acc >> offset, clamped to 15
    always_comb begin
        logic [ACC_W-1:0] shifted;
        shifted = '0;
        for (int i = 0; i < N_BANDS; i++) begin
            shifted    = acc[i] >> offs_q[i*4 +: 4];
            level_c[i] = (shifted > ACC_W'(15)) ? 4'd15 : shifted[3:0];
        end
    end

`ifdef PEAK_HOLD_EN
    logic [3:0] hold_q [N_BANDS];

    // Held level rises to L immediately and decays by one per frame
    always_comb begin
        for (int i = 0; i < N_BANDS; i++) begin
            shown_c[i] = (level_c[i] >= hold_q[i]) ? level_c[i] : hold_q[i] - 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BANDS; i++) hold_q[i] <= 4'd0;
        end else if (state == MAP) begin
            for (int i = 0; i < N_BANDS; i++) hold_q[i] <= shown_c[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < N_BANDS; i++) shown_c[i] = level_c[i];
    end
`endif

    // Colour = {R=L, G=L>>1, B=15-L}
    always_comb begin
        color_c = '0;
        for (int i = 0; i < N_BANDS; i++) begin
            color_c[i*12 +: 12] = {shown_c[i], 1'b0, shown_c[i][3:1], 4'd15 - shown_c[i]};
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bram_addr <= '0;
            color     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            edges_q   <= '0;
            offs_q    <= '0;
            drain_cnt <= '0;
            for (int i = 0; i < N_BANDS; i++) acc[i] <= '0;
        end else begin
            done      <= 1'b0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + CNT_W'(1) : '0;

            if (accept_c) begin
                for (int i = 0; i < N_BANDS; i++) acc[i] <= '0;
            end else if (tag_v[RD_LAT-1]) begin
                acc[tag_b[RD_LAT-1]] <= acc_sat_c;
            end

            case (state)
                IDLE: begin
                    if (accept_c) begin
                        edges_q <= band_edges;
                        offs_q  <= offsets;
                        busy    <= 1'b1;
                        if (last_edge_in_c != '0) bram_addr <= '0;
                    end
                end
                SCAN: begin
                    if (state_nxt == SCAN) bram_addr <= bram_addr + ADDR_W'(1);
                end
                MAP: begin
                    color <= color_c;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_band_color_mapper.sv
// Self-checking bench for fft_band_color_mapper (N_BANDS=7, RD_LAT=2).
module tb_fft_band_color_mapper;

    localparam int BUDGET = 200;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         adjusting;
    logic [69:0]  band_edges;
    logic [27:0]  offsets;
    logic [9:0]   bram_addr;
    logic [15:0]  bram_data;
    logic [83:0]  color;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fft_band_color_mapper dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .adjusting  (adjusting),
        .band_edges (band_edges),
        .offsets    (offsets),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .color      (color),
        .busy       (busy),
        .done       (done)
    );

    // BRAM model with two-cycle read latency
    logic [15:0] mem [1024];
    logic [15:0] rd_p0, rd_p1;
    always @(posedge clock) begin
        rd_p0 <= mem[bram_addr];
        rd_p1 <= rd_p0;
    end
    assign bram_data = rd_p1;

    typedef struct {
        string       name;
        logic [69:0] edges;
        logic [27:0] offs;
        logic [15:0] data;
        logic [83:0] exp_color;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input logic [15:0] d);
        for (int a = 0; a < 1024; a++) mem[a] = d;
    endtask

    // Starts a frame; returns with the bench at the done cycle (lat=0 on timeout)
    task automatic run_frame(input string name, input logic [69:0] e, input logic [27:0] o,
                             input logic [15:0] d, output int lat);
        band_edges = e;
        offsets    = o;
        fill_mem(d);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({name, " busy_c1"}, 84'(busy), 84'(1));
        lat = 0;
        for (int n = 1; n <= BUDGET; n++) begin
            if (n > 1) @(negedge clock);
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) $display("FAIL %s timeout: no done within %0d cycles", name, BUDGET);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        int dones;
        logic [83:0] held_color;

        reset = 1'b1; start = 1'b0; adjusting = 1'b0;
        band_edges = '0; offsets = '0;
        fill_mem(16'd0);

        vecs[0] = '{"uniform1", {10'd56,10'd48,10'd40,10'd32,10'd24,10'd16,10'd8},
                    28'h0, 16'd1, {7{12'h847}}, 60};
        vecs[1] = '{"saturate", {10'd56,10'd48,10'd40,10'd32,10'd24,10'd16,10'd8},
                    {4'd6,4'd5,4'd4,4'd3,4'd2,4'd1,4'd0}, 16'hFFFF, {7{12'hF70}}, 60};
        vecs[2] = '{"empty_bands", {10'd10,10'd10,10'd10,10'd10,10'd10,10'd4,10'd4},
                    28'h0, 16'd2,
                    {12'h00F,12'h00F,12'h00F,12'h00F,12'hC63,12'h00F,12'h847}, 14};
        vecs[3] = '{"offsets", {10'd56,10'd48,10'd40,10'd32,10'd24,10'd16,10'd8},
                    {4'd6,4'd5,4'd4,4'd3,4'd2,4'd1,4'd0}, 16'd3,
                    {12'h00F,12'h00F,12'h10E,12'h31C,12'h639,12'hC63,12'hF70}, 60};
        vecs[4] = '{"zero_scan", 70'h0, 28'h0, 16'd5, {7{12'h00F}}, 4};

        repeat (3) @(negedge clock);
        chk("reset_color", color, 84'h0);
        chk("reset_busy", 84'(busy), 84'(0));
        chk("reset_done", 84'(done), 84'(0));
        chk("reset_addr", 84'(bram_addr), 84'(0));
        reset = 1'b0;
        @(negedge clock);

`ifndef PEAK_HOLD_EN
        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].name, vecs[v].edges, vecs[v].offs, vecs[v].data, lat);
            chk({vecs[v].name, " latency"}, 84'(lat), 84'(vecs[v].exp_lat));
            chk({vecs[v].name, " color"}, color, vecs[v].exp_color);
            chk({vecs[v].name, " busy_done"}, 84'(busy), 84'(0));
            @(negedge clock);
            chk({vecs[v].name, " done_1cyc"}, 84'(done), 84'(0));
            if (vecs[v].edges[69:60] != 10'd0)
                chk({vecs[v].name, " addr_hold"}, 84'(bram_addr), 84'(vecs[v].edges[69:60] - 10'd1));
        end
`endif

        // Restart during scan is ignored; offsets changing mid-scan has no effect
        band_edges = vecs[0].edges;
        offsets    = 28'h0;
        fill_mem(16'd1);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dones = 0;
        lat = 0;
        for (int n = 1; n <= 90; n++) begin
            if (n > 1) @(negedge clock);
            if (done) begin
                dones++;
                if (lat == 0) lat = n;
            end
            start     = (n == 5);
            adjusting = (n >= 10 && n < 20);
            offsets   = (n >= 10 && n < 20) ? 28'hFFFFFFF : 28'h0;
        end
        start = 1'b0; adjusting = 1'b0; offsets = 28'h0;
        chk("restart dones", 84'(dones), 84'(1));
        chk("restart latency", 84'(lat), 84'(60));
        chk("restart color", color, {7{12'h847}});

        // start with adjusting high in IDLE is ignored
        held_color = color;
        @(negedge clock);
        adjusting = 1'b1;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        adjusting = 1'b0;
        dones = 0;
        for (int n = 0; n < 70; n++) begin
            if (done || busy) dones++;
            @(negedge clock);
        end
        chk("adjust_ignored activity", 84'(dones), 84'(0));
        chk("adjust_ignored color", color, held_color);

        // Reset mid-scan abandons the frame
        fill_mem(16'd3);
        offsets = vecs[3].offs;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midreset color", color, 84'h0);
        chk("midreset busy", 84'(busy), 84'(0));
        chk("midreset done", 84'(done), 84'(0));
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("midreset no_done", 84'(dones), 84'(0));
        run_frame("after_reset", vecs[0].edges, 28'h0, 16'd1, lat);
        chk("after_reset latency", 84'(lat), 84'(60));
        chk("after_reset color", color, {7{12'h847}});

`ifdef PEAK_HOLD_EN
        // Held level: 10 then decays 9,8,7,6 while L=0
        do_reset();
        run_frame("peak1", vecs[0].edges, {7{4'd2}}, 16'd5, lat);
        chk("peak1 R0", 84'(color[11:8]), 84'(10));
        for (int f = 0; f < 4; f++) begin
            run_frame("peak_decay", vecs[0].edges, {7{4'd2}}, 16'd0, lat);
            chk("peak_decay R0", 84'(color[11:8]), 84'(9 - f));
            chk("peak_decay R6", 84'(color[83:80]), 84'(9 - f));
        end
`else
        do_reset();
        chk("final_reset color", color, 84'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_band_color_mapper.md
Name: fft_band_color_mapper

Overview:
Parametrised successor to the fixed 7-band FFT-energy/colour path. Scans FFT magnitude BRAM once per frame and accumulates energy into N_BANDS bands with runtime-programmable edges. Scales each band by its own offset and maps it to a 12-bit RGB colour. Publishes all colours atomically to the VGA colour-output stage, with a done pulse.

Parameters:
N_BANDS, 7, number of frequency bands / colour channels
DATA_W, 16, BRAM magnitude width (unsigned)
ADDR_W, 10, BRAM address width
ACC_W, 26, per-band accumulator width
RD_LAT, 2, BRAM read latency in cycles (1..4)

Ports:
clock  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
start  in  1  frame-ready pulse from FFT block
adjusting  in  1  offset edit in progress; start is ignored while high
band_edges  in  N_BANDS*ADDR_W  edge[i] = exclusive upper address of band i; band 0 starts at 0
offsets  in  N_BANDS*4  per-band right-shift amount
bram_addr  out  ADDR_W  FFT BRAM read address
bram_data  in  DATA_W  FFT BRAM read data, valid RD_LAT cycles after address
color  out  N_BANDS*12  packed {R,G,B} per band; band 0 in LSBs
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when color updates

Behaviour:
- Reset, asynchronous and active-high: state IDLE; bram_addr=0; color=0; busy=0; done=0; accumulators=0; pipeline valids cleared. Reset mid-scan abandons the frame, and color returns to 0.
- States: IDLE -> SCAN -> DRAIN -> MAP -> IDLE.
- IDLE: start=1 and adjusting=0 accepts the frame (cycle 0). Latch band_edges and offsets, clear accumulators, go to SCAN. Otherwise stay in IDLE.
- SCAN: cycles 1..E drive bram_addr = 0..E-1, with E = edge[N_BANDS-1]. Each address is tagged with a band index and a valid bit, delayed RD_LAT cycles.
  - Band index = the smallest i with addr < edge[i].
  - A band whose edge <= the previous edge is empty; its accumulator stays 0.
- SCAN exit: after address E-1, go to DRAIN. If E=0, go directly to DRAIN and issue no reads.
- DRAIN: wait until the last tagged read is accumulated. acc[band] += bram_data, saturating at 2^ACC_W-1.
- MAP (cycle E+RD_LAT+1): for each band:
  - L = acc >> offset; saturate L to 15 if (acc >> offset) > 15.
  - colour = {R=L, G=L>>1, B=15-L}.
  - All bands are registered in this cycle.
- Output (cycle E+RD_LAT+2): color updates and done=1 for exactly one cycle; busy falls; state returns to IDLE.
- Total latency: start to done = E+RD_LAT+2 cycles.
- start while busy: ignored, no queueing.
- start and adjusting both high: ignored.
- adjusting changing mid-scan: no effect, because offsets are latched at start.
- bram_addr holds its last value outside SCAN.
- color is stable between done pulses; intermediate values are never visible.

Optional Feature:
PEAK_HOLD_EN
- Defined: each band keeps a held level H (reset 0). At MAP: if L >= H then H = L, else H = H-1. Colour is derived from H.
- Undefined: colour is derived from L directly; no extra state.

Test Plan:
1. N_BANDS=7, RD_LAT=2, edges=8,16,...,56, bram_data=1 everywhere, offsets=0 -> acc=8 each; L=8; each colour 0x847; done exactly 60 cycles after start.
2. Same edges, bram_data=0xFFFF, offset[i]=i -> acc=524280; band 0 L=15 -> 0xF70; every band saturates to 0xF70 (524280>>6 > 15).
3. edges=4,4,10,10,10,10,10 with data=2, offsets=0 -> band0 acc=8 (0x847); band1 empty (0x00F); band2 acc=12 (0xC63); bands 3-6 0x00F; done at E=10 -> cycle 14.
4. start pulsed again at cycle 5 of a scan, and start with adjusting=1 in IDLE -> both ignored; exactly one done pulse; color unchanged by the ignored starts.
5. Assert reset at cycle 20 of a scan -> color=0, busy=0, done never pulses; a new start then completes normally.
6. PEAK_HOLD_EN defined: frame 1 L=10, then frames with L=0 -> held levels 10,9,8,...; colour R field follows the same sequence.
